uart_rx_framed: RTL and testbench



---
 rtl/uart_rx_framed.sv | 126 ++++++++++++
 tb/tb_uart_rx_framed.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/uart_rx_framed.sv
// uart_rx_framed: parametrised UART receiver with parity/framing checks and a valid/ready output register
module uart_rx_framed #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] m_data,
  output logic                 m_parity_err,
  output logic                 m_frame_err,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 overrun
);
  localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int DW = $clog2(DIV);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [DW-1:0] DIV_MAX = DW'(DIV - 1);
  localparam logic [TW-1:0] T_HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_FULL = TW'(OVERSAMPLE - 1);
  localparam logic [3:0] B_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0] B_STOP = 4'(STOP_BITS - 1);
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;
  state_t r_state, w_state_n;
  logic [1:0] r_sync;
  logic [DW-1:0] r_div;
  logic [TW-1:0] r_tick_cnt, w_tick_n;
  logic [3:0] r_bit_cnt, w_bit_n;
  logic [DATA_BITS-1:0] r_shift, w_shift_n;
  logic r_perr, w_perr_n, r_ferr, w_ferr_n, w_done;
  logic w_rx_s, w_tick, w_mid;
  assign w_rx_s = r_sync[1];
  assign w_tick = r_div == DIV_MAX;
  assign w_mid = w_tick && r_tick_cnt == (r_state == S_START ? T_HALF : T_FULL);
  // two-flop synchroniser on the asynchronous line, idling high
  always_ff @(posedge clk)
    r_sync <= rst ? 2'b11 : {r_sync[0], rx};
  // free-running oversample tick divider; never restarted by line activity
  always_ff @(posedge clk)
    r_div <= (rst || w_tick) ? '0 : r_div + 1'b1;
  // frame state and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_tick_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_perr     <= 1'b0;
      r_ferr     <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_tick_cnt <= w_tick_n;
      r_bit_cnt  <= w_bit_n;
      r_shift    <= w_shift_n;
      r_perr     <= w_perr_n;
      r_ferr     <= w_ferr_n;
    end
  end
  // next-state: mid-bit sampling, shift-in, error accumulation and frame completion
  always_comb begin
    w_state_n = r_state;
    w_tick_n  = (w_tick && r_state != S_IDLE) ? r_tick_cnt + 1'b1 : r_tick_cnt;
    w_bit_n   = r_bit_cnt;
    w_shift_n = r_shift;
    w_perr_n  = r_perr;
    w_ferr_n  = r_ferr;
    w_done    = 1'b0;
    case (r_state)
      S_IDLE: if (!w_rx_s) begin
        w_state_n = S_START;
        w_tick_n  = '0;
      end
      S_START: if (w_mid) begin
        w_state_n = w_rx_s ? S_IDLE : S_DATA;
        w_tick_n  = '0;
        w_bit_n   = '0;
        w_perr_n  = 1'b0;
        w_ferr_n  = 1'b0;
      end
      S_DATA: if (w_mid) begin
        w_shift_n = {w_rx_s, r_shift[DATA_BITS-1:1]};
        w_tick_n  = '0;
        w_bit_n   = r_bit_cnt == B_DATA ? 4'd0 : r_bit_cnt + 1'b1;
        w_state_n = r_bit_cnt != B_DATA ? S_DATA : (PARITY != 0 ? S_PAR : S_STOP);
      end
      S_PAR: if (w_mid) begin
        w_perr_n  = (^r_shift ^ w_rx_s) != (PARITY == 1);
        w_tick_n  = '0;
        w_state_n = S_STOP;
      end
      S_STOP: if (w_mid) begin
        w_ferr_n  = r_ferr | !w_rx_s;
        w_tick_n  = '0;
        w_bit_n   = r_bit_cnt + 1'b1;
        w_done    = r_bit_cnt == B_STOP;
        w_state_n = r_bit_cnt == B_STOP ? S_IDLE : S_STOP;
      end
      default: w_state_n = S_IDLE;
    endcase
  end
  // one-entry output register: load on completion when free, drop and flag overrun when full
  always_ff @(posedge clk) begin
    if (rst) begin
      m_data       <= '0;
      m_parity_err <= 1'b0;
      m_frame_err  <= 1'b0;
      m_valid      <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      overrun <= w_done && m_valid && !m_ready;
      if (w_done && (!m_valid || m_ready)) begin
        m_data       <= r_shift;
        m_parity_err <= r_perr;
        m_frame_err  <= w_ferr_n;
        m_valid      <= 1'b1;
      end else if (m_valid && m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_uart_rx_framed.sv
// tb_uart_rx_framed: table-driven and scoreboard checks over 8N1, 8E1 and 8N2 receivers
module tb_uart_rx_framed;
  localparam int BIT = 160;
  typedef struct {int u; logic [7:0] d; logic par; logic [1:0] stp; logic [7:0] ed; logic pe; logic fe;} vec_t;
  typedef struct {int u; logic [7:0] d; logic pe; logic fe;} exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] rx_l = '1;
  logic [2:0] rdy = '1;
  logic [7:0] md [3];
  logic [2:0] mv, mpe, mfe, ovr;
  exp_t q[$];
  int total = 0;
  int bad = 0;
  int ovr_cnt [3] = '{0, 0, 0};
  int deliv [3] = '{0, 0, 0};
  vec_t tv [10];
  always #5 clk = ~clk;
  uart_rx_framed #(.CLK_FREQ(1_600_000), .BAUD(10_000), .OVERSAMPLE(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
    .clk(clk), .rst(rst), .rx(rx_l[0]), .m_data(md[0]), .m_parity_err(mpe[0]), .m_frame_err(mfe[0]),
    .m_valid(mv[0]), .m_ready(rdy[0]), .overrun(ovr[0]));
  uart_rx_framed #(.CLK_FREQ(1_600_000), .BAUD(10_000), .OVERSAMPLE(16), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u1 (
    .clk(clk), .rst(rst), .rx(rx_l[1]), .m_data(md[1]), .m_parity_err(mpe[1]), .m_frame_err(mfe[1]),
    .m_valid(mv[1]), .m_ready(rdy[1]), .overrun(ovr[1]));
  uart_rx_framed #(.CLK_FREQ(1_600_000), .BAUD(10_000), .OVERSAMPLE(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u2 (
    .clk(clk), .rst(rst), .rx(rx_l[2]), .m_data(md[2]), .m_parity_err(mpe[2]), .m_frame_err(mfe[2]),
    .m_valid(mv[2]), .m_ready(rdy[2]), .overrun(ovr[2]));
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  task automatic line(input int u, input logic b, input int n);
    rx_l[u] = b;
    repeat (n) @(posedge clk);
    #2;
  endtask
  // stop bits sent as 0 are low only for the sampled part of the bit so the resync start check sees idle
  task automatic send(input int u, input logic [7:0] d, input logic par, input logic [1:0] stp);
    line(u, 1'b0, BIT);
    for (int i = 0; i < 8; i++) line(u, d[i], BIT);
    if (u == 1) line(u, par, BIT);
    for (int i = 0; i < (u == 2 ? 2 : 1); i++)
      if (stp[i]) line(u, 1'b1, BIT);
      else begin
        line(u, 1'b0, 120);
        line(u, 1'b1, 40);
      end
    line(u, 1'b1, 200);
  endtask
  task automatic drain(input string name, input int budget);
    int n = 0;
    while (q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, q.size(), 0);
    q.delete();
  endtask
  // scoreboard: every transfer pops the oldest expected word and compares it
  always @(negedge clk) begin
    for (int u = 0; u < 3; u++) begin
      if (ovr[u]) ovr_cnt[u]++;
      if (!rst && mv[u] && rdy[u]) begin
        exp_t e;
        deliv[u]++;
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_word unit%0d: got %0h want none", u, md[u]);
        end else begin
          e = q.pop_front();
          if (e.u != u || e.d !== md[u] || e.pe !== mpe[u] || e.fe !== mfe[u]) begin
            bad++;
            $display("FAIL word unit%0d: got d=%0h pe=%0b fe=%0b want unit%0d d=%0h pe=%0b fe=%0b",
                     u, md[u], mpe[u], mfe[u], e.u, e.d, e.pe, e.fe);
          end
        end
      end
    end
  end
  initial begin
    int o, dv;
    tv[0] = '{0, 8'hA5, 1'b0, 2'b11, 8'hA5, 1'b0, 1'b0};
    tv[1] = '{0, 8'h3C, 1'b0, 2'b10, 8'h3C, 1'b0, 1'b1};
    tv[2] = '{0, 8'h00, 1'b0, 2'b11, 8'h00, 1'b0, 1'b0};
    tv[3] = '{1, 8'h03, 1'b1, 2'b11, 8'h03, 1'b1, 1'b0};
    tv[4] = '{1, 8'h03, 1'b0, 2'b11, 8'h03, 1'b0, 1'b0};
    tv[5] = '{1, 8'h80, 1'b1, 2'b11, 8'h80, 1'b0, 1'b0};
    tv[6] = '{1, 8'h80, 1'b0, 2'b11, 8'h80, 1'b1, 1'b0};
    tv[7] = '{2, 8'h5A, 1'b0, 2'b11, 8'h5A, 1'b0, 1'b0};
    tv[8] = '{2, 8'h5A, 1'b0, 2'b01, 8'h5A, 1'b0, 1'b1};
    tv[9] = '{1, 8'hC3, 1'b1, 2'b10, 8'hC3, 1'b1, 1'b1};
    repeat (5) @(posedge clk);
    #2;
    for (int u = 0; u < 3; u++) begin
      chk($sformatf("rst_data%0d", u), md[u], 0);
      chk($sformatf("rst_flags%0d", u), {mv[u], mpe[u], mfe[u], ovr[u]}, 0);
    end
    rst = 1'b0;
    line(0, 1'b1, 20);
    for (int i = 0; i < 10; i++) begin
      q.push_back('{tv[i].u, tv[i].ed, tv[i].pe, tv[i].fe});
      send(tv[i].u, tv[i].d, tv[i].par, tv[i].stp);
      drain($sformatf("vec%0d_delivered", i), 400);
      chk($sformatf("vec%0d_valid_low", i), mv[tv[i].u], 0);
      chk($sformatf("vec%0d_no_overrun", i), ovr_cnt[tv[i].u], 0);
    end
    dv = deliv[0];
    line(0, 1'b0, 40);
    line(0, 1'b1, 400);
    chk("false_start_no_word", deliv[0] - dv, 0);
    chk("false_start_valid", mv[0], 0);
    q.push_back('{0, 8'h7E, 1'b0, 1'b0});
    send(0, 8'h7E, 1'b0, 2'b11);
    drain("after_false_start", 400);
    rdy[0] = 1'b0;
    q.push_back('{0, 8'h11, 1'b0, 1'b0});
    send(0, 8'h11, 1'b0, 2'b11);
    chk("bp_valid", mv[0], 1);
    chk("bp_data_first", md[0], 8'h11);
    o = ovr_cnt[0];
    send(0, 8'h22, 1'b0, 2'b11);
    chk("bp_data_held", md[0], 8'h11);
    chk("bp_still_valid", mv[0], 1);
    chk("bp_overrun_once", ovr_cnt[0] - o, 1);
    rdy[0] = 1'b1;
    @(posedge clk);
    #2;
    chk("bp_valid_drop", mv[0], 0);
    drain("bp_transfer", 10);
    chk("bp_data_kept", md[0], 8'h11);
    dv = deliv[0];
    o = ovr_cnt[0];
    line(0, 1'b0, BIT);
    for (int i = 0; i < 4; i++) line(0, 1'b1, BIT);
    rst = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    line(0, 1'b1, 12 * BIT);
    chk("rst_mid_no_word", deliv[0] - dv, 0);
    chk("rst_mid_no_overrun", ovr_cnt[0] - o, 0);
    q.push_back('{0, 8'h5A, 1'b0, 1'b0});
    send(0, 8'h5A, 1'b0, 2'b11);
    drain("rst_mid_next_word", 400);
    chk("rst_mid_single", deliv[0] - dv, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
